// File: rtl/fsb_cycle_ctrl.sv
// FSB cycle controller: arbitrates CPU bus cycles (RAM/ROM/IO) against periodic DRAM refresh
// and produces Ready / nBERR handshakes. All outputs are pure decodes of the state register.
`timescale 1ns/1ps
module fsb_cycle_ctrl #(
    parameter int ROMWS  = 2,
    parameter int REFDIV = 96,
    parameter int REFLEN = 4
) (
    input  logic FCLK,
    input  logic nRES,
    input  logic ASActive,
    input  logic ASInactive,
    input  logic RAMCS,
    input  logic ROMCS,
    input  logic IOCS,
    input  logic RAMReady,
    input  logic IOReady,
    input  logic TimeoutB,
    output logic Ready,
    output logic nBERR,
    output logic RAMReq,
    output logic RefReq,
    output logic IOReq,
    output logic Busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REF  = 3'd1,
        RAM  = 3'd2,
        ROM  = 3'd3,
        IO   = 3'd4,
        DONE = 3'd5,
        BERR = 3'd6
    } state_t;

    localparam logic [3:0] ROM_LOAD   = 4'(ROMWS - 1);
    localparam logic [3:0] REF_LOAD   = 4'(REFLEN - 1);
    localparam logic [7:0] REF_RELOAD = 8'(REFDIV - 1);

    state_t     state, state_nxt;
    logic [3:0] wait_cnt, wait_nxt;   // ROM wait states, reused for refresh length
    logic [7:0] ref_cnt;
    logic       ref_pend;
    logic       ref_wrap;
    logic       ref_take;

    assign ref_wrap = (ref_cnt == 8'd0);
    assign ref_take = (state == IDLE) && ref_pend;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        unique case (state)
            IDLE: begin
                if (ref_pend) begin
                    state_nxt = REF;
                    wait_nxt  = REF_LOAD;
                end else if (ASActive) begin
                    if (RAMCS) begin
                        state_nxt = RAM;
                    end else if (ROMCS) begin
                        state_nxt = ROM;
                        wait_nxt  = ROM_LOAD;
                    end else if (IOCS) begin
                        state_nxt = IO;
                    end else begin
                        state_nxt = BERR;
                    end
                end
            end
            REF: begin
                if (wait_cnt == 4'd0) state_nxt = IDLE;
                else                  wait_nxt  = wait_cnt - 4'd1;
            end
            // Abort beats timeout, timeout beats ready.
            RAM: begin
                if (ASInactive)    state_nxt = IDLE;
                else if (TimeoutB) state_nxt = BERR;
                else if (RAMReady) state_nxt = DONE;
            end
            ROM: begin
                if (ASInactive)             state_nxt = IDLE;
                else if (TimeoutB)          state_nxt = BERR;
                else if (wait_cnt == 4'd0)  state_nxt = DONE;
                else                        wait_nxt  = wait_cnt - 4'd1;
            end
            IO: begin
                if (ASInactive)    state_nxt = IDLE;
                else if (TimeoutB) state_nxt = BERR;
                else if (IOReady)  state_nxt = DONE;
            end
            DONE, BERR: begin
                if (ASInactive) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge FCLK or negedge nRES) begin
        if (!nRES) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Free-running refresh timer; a wrap always wins over the clear so a refresh is never lost.
    always_ff @(posedge FCLK or negedge nRES) begin
        if (!nRES) begin
            ref_cnt  <= REF_RELOAD;
            ref_pend <= 1'b0;
        end else begin
            ref_cnt <= ref_wrap ? REF_RELOAD : ref_cnt - 8'd1;
            if (ref_wrap)      ref_pend <= 1'b1;
            else if (ref_take) ref_pend <= 1'b0;
        end
    end

    assign RefReq = (state == REF);
    assign RAMReq = (state == RAM);
    assign IOReq  = (state == IO);
    assign Ready  = (state == DONE);
    assign nBERR  = (state != BERR);
    assign Busy   = (state != IDLE);

endmodule

// File: tb/tb_fsb_cycle_ctrl.sv
// Randomised scoreboard bench for fsb_cycle_ctrl: stimulus predicts each bus-cycle outcome,
// an independent monitor reconstructs outcomes from the outputs and compares.
`timescale 1ns/1ps
module tb_fsb_cycle_ctrl;

    localparam int ROMWS  = 2;
    localparam int REFDIV = 40;
    localparam int REFLEN = 4;

    typedef enum logic [1:0] {R_DONE, R_BERR, R_ABORT} resp_e;
    typedef enum logic [1:0] {K_NONE, K_RAM, K_ROM, K_IO} kind_e;
    typedef struct packed {
        resp_e      resp;
        kind_e      kind;
        logic [7:0] len;
    } exp_t;

    logic FCLK, nRES;
    logic ASActive, ASInactive, RAMCS, ROMCS, IOCS, RAMReady, IOReady, TimeoutB;
    logic Ready, nBERR, RAMReq, RefReq, IOReq, Busy;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   since_rel;
    int   ref_runs = 0;
    logic as_inact_q;

    fsb_cycle_ctrl #(.ROMWS(ROMWS), .REFDIV(REFDIV), .REFLEN(REFLEN)) dut (
        .FCLK(FCLK), .nRES(nRES),
        .ASActive(ASActive), .ASInactive(ASInactive),
        .RAMCS(RAMCS), .ROMCS(ROMCS), .IOCS(IOCS),
        .RAMReady(RAMReady), .IOReady(IOReady), .TimeoutB(TimeoutB),
        .Ready(Ready), .nBERR(nBERR), .RAMReq(RAMReq), .RefReq(RefReq),
        .IOReq(IOReq), .Busy(Busy)
    );

    initial FCLK = 1'b0;
    always #5 FCLK = ~FCLK;

    always @(posedge FCLK or negedge nRES) begin
        if (!nRES) since_rel <= 0;
        else       since_rel <= since_rel + 1;
    end

    always @(posedge FCLK) as_inact_q <= ASInactive;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic access_vis();
        return RAMReq || IOReq || (Busy && !RefReq && !Ready && nBERR);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge FCLK) begin : mon
        kind_e k;
        exp_t  got, want;
        logic  excl_ok;
        static kind_e run_kind = K_NONE;
        static int    run_len = 0, ref_len = 0;
        static logic  prev_ready = 1'b0, prev_berr = 1'b0, prev_ref = 1'b0;
        static logic  have_evt = 1'b0;

        if (!nRES) begin
            run_len = 0; run_kind = K_NONE; ref_len = 0;
            prev_ready = 1'b0; prev_berr = 1'b0; prev_ref = 1'b0;
        end else begin
            excl_ok = !(Ready && !nBERR) && ($countones({RefReq, RAMReq, IOReq}) <= 1)
                      && (Busy || (!Ready && nBERR && !RefReq && !RAMReq && !IOReq));
            check("exclusive_outputs", excl_ok, 1'b1);

            have_evt = 1'b0;
            got = '0;
            k = RAMReq ? K_RAM : IOReq ? K_IO : access_vis() ? K_ROM : K_NONE;
            if (k != K_NONE) begin
                if (run_len > 0 && run_kind == k) run_len++;
                else begin run_kind = k; run_len = 1; end
            end else if ((Ready && !prev_ready) || (!nBERR && !prev_berr)) begin
                got.resp = Ready ? R_DONE : R_BERR;
                got.kind = (run_len > 0) ? run_kind : K_NONE;
                got.len  = 8'(run_len);
                have_evt = 1'b1;
                run_len  = 0;
            end else if (!Busy && run_len > 0) begin
                got.resp = R_ABORT;
                got.kind = run_kind;
                got.len  = 8'(run_len);
                have_evt = 1'b1;
                run_len  = 0;
            end else begin
                run_len = 0;
            end

            if (have_evt) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_cycle_event: got %0h, expected none", got);
                end else begin
                    want = exp_q.pop_front();
                    check("cycle_result(resp,kind,len)", got, want);
                end
            end

            // Ready / bus error may only drop on an edge where ASInactive was seen.
            if (prev_ready && !Ready) check("done_hold_until_asinactive", as_inact_q, 1'b1);
            if (prev_berr && nBERR)   check("berr_hold_until_asinactive", as_inact_q, 1'b1);

            if (RefReq) begin
                if (!prev_ref) ref_runs++;
                ref_len++;
            end else if (prev_ref) begin
                check("refresh_length", ref_len, REFLEN);
                ref_len = 0;
            end

            prev_ready = Ready;
            prev_berr  = !nBERR;
            prev_ref   = RefReq;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        ASActive = 0; ASInactive = 0; RAMCS = 0; ROMCS = 0; IOCS = 0;
        RAMReady = 0; IOReady = 0; TimeoutB = 0;
    endtask

    // Runs one CPU bus cycle; dly = extra cycles before ready/timeout/abort for RAM/IO,
    // extra = also raise the losing condition(s) in the same cycle.
    task automatic do_cycle(input kind_e kind, input int dly, input bit err, input bit abort,
                            input bit extra);
        exp_t e;
        bit   found, seen;
        @(negedge FCLK);
        ASActive = 1; ASInactive = 0;
        RAMCS = (kind == K_RAM);
        ROMCS = (kind == K_ROM) || (kind == K_RAM && $urandom_range(0, 1) == 1);
        IOCS  = (kind == K_IO)  || (kind != K_NONE && $urandom_range(0, 1) == 1);

        e.kind = kind;
        if (kind == K_NONE) begin
            e.resp = R_BERR; e.len = 8'd0;
        end else begin
            e.resp = abort ? R_ABORT : err ? R_BERR : R_DONE;
            if (kind == K_ROM) e.len = (abort || err) ? 8'd1 : 8'(ROMWS);
            else               e.len = 8'(dly + 1);
        end
        exp_q.push_back(e);

        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge FCLK);
            if (access_vis() || !nBERR) begin found = 1; break; end
        end
        check("cycle_started", found, 1'b1);

        if (found && kind != K_NONE) begin
            if (kind != K_ROM) repeat (dly) @(negedge FCLK);
            if (abort) begin
                ASActive = 0; ASInactive = 1;
                if (extra) begin RAMReady = 1; IOReady = 1; TimeoutB = 1; end
            end else if (err) begin
                TimeoutB = 1;
                if (extra) begin RAMReady = (kind == K_RAM); IOReady = (kind == K_IO); end
            end else if (kind == K_RAM) begin
                RAMReady = 1;
            end else if (kind == K_IO) begin
                IOReady = 1;
            end
        end

        if (found && !abort) begin
            seen = !nBERR;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge FCLK);
                RAMReady = 0; IOReady = 0; TimeoutB = 0;
                seen = Ready || !nBERR;
            end
            check("response_seen", seen, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge FCLK);
        end
        if (!abort || !found) @(negedge FCLK);
        RAMReady = 0; IOReady = 0; TimeoutB = 0;
        ASActive = 0; RAMCS = 0; ROMCS = 0; IOCS = 0; ASInactive = 1;
        @(negedge FCLK);
        ASInactive = 0;
    endtask

    task automatic wait_first_ref();
        int n;
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge FCLK);
            if (RefReq) begin n = i; break; end
        end
        // Pending raised on the REFDIV-th edge after release, REF entered on the next.
        check("first_refresh_after_reset", n, REFDIV + 1);
    endtask

    task automatic random_cycles(input int count);
        kind_e k;
        int    r;
        for (int i = 0; i < count; i++) begin
            r = int'($urandom_range(0, 99));
            k = (r < 40) ? K_RAM : (r < 65) ? K_ROM : (r < 90) ? K_IO : K_NONE;
            do_cycle(k, int'($urandom_range(0, 4)), $urandom_range(0, 99) < 15,
                     $urandom_range(0, 99) < 10, $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 3)) @(negedge FCLK);
        end
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit seen;
        idle_inputs();
        nRES = 0;
        repeat (3) @(negedge FCLK);
        check("reset_outputs", {Ready, nBERR, RAMReq, RefReq, IOReq, Busy}, 6'b010000);
        nRES = 1;
        wait_first_ref();

        // Refresh collides with a RAM request arriving in IDLE.
        for (int i = 0; i < 1000 && since_rel != 2 * REFDIV - 1; i++) @(negedge FCLK);
        do_cycle(K_RAM, 3, 0, 0, 0);
        check("refresh_runs_after_collision", ref_runs, 2);

        do_cycle(K_ROM,  0, 0, 0, 0);
        do_cycle(K_NONE, 0, 0, 0, 0);
        do_cycle(K_IO,   2, 1, 0, 0);
        do_cycle(K_IO,   1, 1, 0, 1);
        do_cycle(K_RAM,  2, 0, 1, 0);
        do_cycle(K_RAM,  0, 0, 1, 1);
        do_cycle(K_ROM,  0, 1, 0, 0);
        do_cycle(K_ROM,  0, 0, 1, 0);
        do_cycle(K_IO,   0, 0, 0, 0);
        random_cycles(150);

        // Asynchronous reset while DONE is being held.
        @(negedge FCLK);
        exp_q.push_back(exp_t'{resp: R_DONE, kind: K_RAM, len: 8'd1});
        ASActive = 1; RAMCS = 1; RAMReady = 1;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge FCLK);
            seen = Ready;
        end
        check("ready_before_reset", seen, 1'b1);
        RAMReady = 0;
        #2;
        nRES = 0;
        #1;
        check("async_reset_outputs", {Ready, nBERR, RAMReq, RefReq, IOReq, Busy}, 6'b010000);
        idle_inputs();
        repeat (2) @(negedge FCLK);
        nRES = 1;
        wait_first_ref();

        random_cycles(40);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge FCLK);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
